laser_frame_transmitter: RTL and testbench

//   Divider-timed serial framer that drives one laser channel. Its frames are
//   bit-compatible with LaserReceiver when both use the same divider value.

---
 rtl/laser_frame_transmitter.sv | 196 +++++++++++++++++++
 tb/tb_laser_frame_transmitter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_frame_transmitter.sv
// ---------------------------------------------------------------------------
// laser_frame_transmitter
//   Divider-timed serial framer driving one laser channel. Bytes arrive via a
//   ready/valid handshake into a DEPTH-entry FIFO and are sent as: start bit 1,
//   8 data bits LSB first, stop bit 0. Every bit lasts div_q clocks, where
//   div_q is the divider input latched (clamped to >= 2) when a byte is popped.
//
//   Optional feature macro: LASER_TX_IDLE_GAP_EN
//     When defined, a GAP state holds the line at 0 for div_q extra clocks
//     after each stop bit. The done pulse still marks the end of the stop bit.
//
// Ports
//   clock       sole clock, posedge
//   reset_n     asynchronous active-low reset
//   en          transmit enable; low aborts the frame in flight
//   divider     clocks per bit (values < 2 behave as 2)
//   data_in     byte to enqueue
//   data_valid  data_in valid this cycle
//   data_ready  FIFO not full
//   laser_out   registered line output, idle 0
//   busy        a frame is in progress
//   done        one-cycle pulse once the stop bit has completed on the line
//   fifo_count  FIFO occupancy
// ---------------------------------------------------------------------------
module laser_frame_transmitter #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [7:0]               divider,
    input  logic [7:0]               data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    output logic                     laser_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef LASER_TX_IDLE_GAP_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic [7:0]      bclk;
    logic [2:0]      bidx;
    logic [7:0]      shreg;
    logic [7:0]      div_q;
    logic            stop_end;   // stop bit just finished in the FSM
    logic            frame_end;  // first IDLE cycle after a completed frame

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;

    logic            full;
    logic            push;
    logic            pop;
    logic            bit_last;
    logic [7:0]      div_clamp;

    assign full       = (count == CW'(DEPTH));
    assign push       = data_valid & ~full;
    // The idle cycle following a completed frame never pops, which yields the
    // 2-clock line-low gap between back-to-back frames.
    assign pop        = (state == IDLE) & en & (count != '0) & ~frame_end;
    assign data_ready = ~full;
    assign fifo_count = count;
    assign div_clamp  = (divider < 8'd2) ? 8'd2 : divider;
    assign bit_last   = (bclk == div_q - 8'd1);

    // FIFO storage: no reset needed, occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // laser_out is registered from the pre-edge state, so the line trails the
    // FSM by one clock; done is delayed through stop_end to stay aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bclk      <= '0;
            bidx      <= '0;
            shreg     <= '0;
            div_q     <= 8'd2;
            stop_end  <= 1'b0;
            frame_end <= 1'b0;
            laser_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= stop_end;
            stop_end  <= 1'b0;
            frame_end <= 1'b0;
            if (state == IDLE) begin
                laser_out <= 1'b0;
                if (pop) begin
                    shreg <= mem[rptr];
                    div_q <= div_clamp;
                    bclk  <= '0;
                    bidx  <= '0;
                    busy  <= 1'b1;
                    state <= START;
                end
            end else if (!en) begin
                state     <= IDLE;
                laser_out <= 1'b0;
                bclk      <= '0;
                busy      <= 1'b0;
            end else begin
                if (bit_last) begin
                    bclk <= '0;
                end else begin
                    bclk <= bclk + 8'd1;
                end
                case (state)
                    START: begin
                        laser_out <= 1'b1;
                        if (bit_last) begin
                            bidx  <= '0;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        laser_out <= shreg[0];
                        if (bit_last) begin
                            shreg <= {1'b0, shreg[7:1]};
                            bidx  <= bidx + 3'd1;
                            if (bidx == 3'd7) begin
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        laser_out <= 1'b0;
                        if (bit_last) begin
                            stop_end <= 1'b1;
`ifdef LASER_TX_IDLE_GAP_EN
                            state    <= GAP;
`else
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_end <= 1'b1;
`endif
                        end
                    end
`ifdef LASER_TX_IDLE_GAP_EN
                    GAP: begin
                        laser_out <= 1'b0;
                        if (bit_last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_end <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        laser_out <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_laser_frame_transmitter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for laser_frame_transmitter. A timeline model predicts
// every output from the last popped frame (pop edge, divider, byte, abort
// edge) and a queue standing in for the FIFO.
// ---------------------------------------------------------------------------
module tb_laser_frame_transmitter;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int HIST  = 16384;
    localparam int INF   = 32'h7fff_ffff;
`ifdef LASER_TX_IDLE_GAP_EN
    localparam int GAPM  = 1;
`else
    localparam int GAPM  = 0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic [7:0]    divider = 8'd4;
    logic [7:0]    data_in = 8'd0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          laser_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] fifo_count;

    always #5 clock = ~clock;

    laser_frame_transmitter #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (en),
        .divider    (divider),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .laser_out  (laser_out),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // model state
    int            n = 0;
    byte unsigned  q[$];
    int            fP = -100000;
    int            fd = 2;
    int            fL = 20;
    int            fA = 0;
    logic [7:0]    fb = 8'd0;
    int            pop_ok_from = 0;
    bit            eh_l [HIST];
    bit            eh_d [HIST];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    function automatic bit m_busy(input int e);
        return (e < fA) && (e - fP >= 0) && (e - fP < fL);
    endfunction

    function automatic bit m_laser(input int e);
        int t;
        int idx;
        t = e - fP;
        if (e >= fA || t < 1 || t > 10 * fd) return 1'b0;
        idx = (t - 1) / fd;
        if (idx == 0) return 1'b1;
        if (idx == 9) return 1'b0;
        return fb[idx-1];
    endfunction

    function automatic bit m_done(input int e);
        return (e - fP == 10 * fd + 1) && (fA > fP + 10 * fd);
    endfunction

    task automatic step();
        int pre_size;
        bit pre_busy;
        @(posedge clock);
        n = n + 1;
        if (!reset_n) begin
            q.delete();
            fP = -100000;
            fA = 0;
            pop_ok_from = 0;
        end else begin
            pre_size = q.size();
            pre_busy = m_busy(n - 1);
            if (pre_busy && !en) begin
                fA = n;
                pop_ok_from = n + 1;
            end else if (!pre_busy && en && pre_size > 0 && n >= pop_ok_from) begin
                fP = n;
                fd = (int'(divider) < 2) ? 2 : int'(divider);
                fb = q.pop_front();
                fL = 10 * fd + GAPM * fd;
                fA = INF;
                pop_ok_from = n + fL + 2;
            end
            if (data_valid && pre_size < DEPTH) q.push_back(data_in);
        end
        if (n < HIST) begin
            eh_l[n] = m_laser(n);
            eh_d[n] = m_done(n);
        end
        @(negedge clock);
        chk("laser_out",  64'(laser_out),  64'(m_laser(n)));
        chk("done",       64'(done),       64'(m_done(n)));
        chk("busy",       64'(busy),       64'(m_busy(n)));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("data_ready", 64'(data_ready), 64'(q.size() < DEPTH));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    function automatic int first_rise(input int from, input int to);
        for (int e = from; e <= to && e < HIST; e++) if (eh_l[e]) return e;
        return -1;
    endfunction

    function automatic int first_done(input int from, input int to);
        for (int e = from; e <= to && e < HIST; e++) if (eh_d[e]) return e;
        return -1;
    endfunction

    initial begin
        int push_edge;
        int rise;
        int dn;
        int pop_e;
        int abort_e;
        int cnt;
        logic [39:0] wave;
        int dq[$];

        // reset held for 3 cycles
        run(3);
        chk("rst_laser",  64'(laser_out),  64'd0);
        chk("rst_ready",  64'(data_ready), 64'd1);
        chk("rst_count",  64'(fifo_count), 64'd0);
        chk("rst_busy",   64'(busy),       64'd0);
        reset_n = 1'b1;
        run(2);

        // 0xA5 at divider 4
        en = 1'b1; divider = 8'd4; data_in = 8'hA5; data_valid = 1'b1;
        step();
        push_edge = n;
        data_valid = 1'b0;
        run(50);
        rise = first_rise(push_edge + 1, push_edge + 50);
        chk("a5_latency", 64'(rise - push_edge), 64'd2);
        wave = '0;
        for (int i = 0; i < 40; i++) wave = {wave[38:0], (rise >= 0) ? eh_l[rise + i] : 1'b0};
        chk("a5_wave", 64'(wave), 64'h00_FF0F00F0F0);
        dn = first_done(push_edge + 1, push_edge + 50);
        chk("a5_done", 64'(dn - rise), 64'd40);

        // divider 1 behaves as 2
        divider = 8'd1; data_in = 8'h3C; data_valid = 1'b1;
        step();
        push_edge = n;
        data_valid = 1'b0;
        run(30);
        rise = first_rise(push_edge + 1, push_edge + 30);
        dn = first_done(push_edge + 1, push_edge + 30);
        chk("div1_frame", 64'(dn - rise), 64'd20);

        // overfill while disabled, then drain back-to-back
        en = 1'b0; divider = 8'd3; data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'(8'h81 >> i) | 8'(8'h01 << i);
            step();
        end
        data_valid = 1'b0;
        chk("ovf_model_count", 64'(q.size()), 64'd4);
        chk("ovf_count", 64'(fifo_count), 64'd4);
        chk("ovf_ready", 64'(data_ready), 64'd0);
        en = 1'b1;
        push_edge = n;
        run(160);
        for (int e = push_edge + 1; e <= n; e++) if (eh_d[e]) dq.push_back(e);
        chk("b2b_frames", 64'(dq.size()), 64'd4);
        for (int i = 1; i < dq.size(); i++)
            chk("b2b_period", 64'(dq[i] - dq[i-1]), (GAPM != 0) ? 64'd35 : 64'd32);

        // abort on data bit 3 of 0xFF, then 0x5A goes out whole
        divider = 8'd4; data_in = 8'hFF; data_valid = 1'b1;
        step();
        data_in = 8'h5A;
        step();
        pop_e = n;
        data_valid = 1'b0;
        run(17);
        en = 1'b0;
        step();
        abort_e = n;
        en = 1'b1;
        run(51);
        chk("abort_before", 64'(eh_l[abort_e - 1]), 64'd1);
        chk("abort_after",  64'(eh_l[abort_e]),     64'd0);
        cnt = 0;
        for (int e = pop_e; e <= abort_e + 45; e++) if (eh_d[e]) cnt++;
        chk("abort_dones", 64'(cnt), 64'd1);
        rise = first_rise(abort_e + 1, abort_e + 10);
        chk("abort_resend", 64'(rise - abort_e), 64'd2);

        // randomized traffic with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            en         = ($urandom_range(0, 39) != 0);
            data_valid = ($urandom_range(0, 2) == 0);
            data_in    = 8'($urandom);
            divider    = 8'($urandom_range(0, 5));
            reset_n    = !(i >= 1500 && i < 1502);
            step();
        end
        reset_n = 1'b1;
        en = 1'b0;
        data_valid = 1'b0;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", n);
        $fatal(1, "time limit");
    end

endmodule
